// File: rtl/quick_spi_slave.sv
// SPI responder: one DATA_WIDTH-bit frame per ss_n assertion, oversampled in the clk domain.
// Captures MOSI into rx_data and shifts a preloaded tx word out on MISO.
module quick_spi_slave #(
  parameter int   DATA_WIDTH      = 16,
  parameter int   BITS_ORDER      = 1,
  parameter int   CPOL            = 0,
  parameter int   CPHA            = 0,
  parameter logic MISO_IDLE_VALUE = 1'b0,
  parameter int   SYNC_STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  ss_n,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_error
);

  localparam int   CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam int   FIRST    = (BITS_ORDER != 0) ? DATA_WIDTH - 1 : 0;
  localparam logic IDLE_CLK = (CPOL != 0);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync, warm;
  logic                   sclk_prev, ss_prev;
  logic [DATA_WIDTH-1:0]  tx_buf, shift_tx, rx_shift;
  logic                   tx_full;
  logic [CNT_W-1:0]       bit_cnt;

  logic sclk_s, mosi_s, ss_s;
  logic leading, trailing, sample_edge, shift_edge, ss_fall;
  logic [DATA_WIDTH-1:0] load_word, rx_next;

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] x);
    if (BITS_ORDER != 0) return {x[DATA_WIDTH-2:0], 1'b0};
    else                 return {1'b0, x[DATA_WIDTH-1:1]};
  endfunction

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign ss_s        = ss_sync[SYNC_STAGES-1];
  assign leading     = (sclk_s != sclk_prev) && (sclk_prev == IDLE_CLK);
  assign trailing    = (sclk_s != sclk_prev) && (sclk_prev != IDLE_CLK);
  assign sample_edge = (CPHA == 0) ? leading : trailing;
  assign shift_edge  = (CPHA == 0) ? trailing : leading;
  assign ss_fall     = ss_prev && !ss_s;
  assign load_word   = tx_full ? tx_buf : '0;
  assign rx_next     = (BITS_ORDER != 0) ? {rx_shift[DATA_WIDTH-2:0], mosi_s}
                                         : {mosi_s, rx_shift[DATA_WIDTH-1:1]};
  assign tx_ready    = !tx_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= {SYNC_STAGES{IDLE_CLK}};
      mosi_sync <= '0;
      ss_sync   <= '1;
      warm      <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      warm      <= {warm[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sclk_prev   <= IDLE_CLK;
      ss_prev     <= 1'b0;
      miso        <= MISO_IDLE_VALUE;
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      shift_tx    <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_error <= 1'b0;
      bit_cnt     <= '0;
    end else begin
      sclk_prev   <= sclk_s;
      // A falling ss_n only counts once a genuinely sampled high has been seen,
      // so a select held low through reset cannot start a frame.
      ss_prev     <= warm[SYNC_STAGES-1] && ss_s;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_error <= 1'b0;
      if (tx_valid && !tx_full) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          miso <= MISO_IDLE_VALUE;
          if (ss_fall && enable) begin
            state    <= ACTIVE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            if (!tx_full) tx_underrun <= 1'b1;
            if (CPHA == 0) begin
              miso     <= load_word[FIRST];
              shift_tx <= shift_out(load_word);
            end else begin
              shift_tx <= load_word;
            end
          end
        end
        ACTIVE: begin
          if (ss_s) begin
            state       <= IDLE;
            frame_error <= 1'b1;
            miso        <= MISO_IDLE_VALUE;
            bit_cnt     <= '0;
          end else begin
            if (shift_edge) begin
              miso     <= shift_tx[FIRST];
              shift_tx <= shift_out(shift_tx);
            end
            if (sample_edge) begin
              rx_shift <= rx_next;
              bit_cnt  <= bit_cnt + CNT_W'(1);
              if (bit_cnt == LAST_BIT) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                tx_full  <= 1'b0;
                miso     <= MISO_IDLE_VALUE;
                state    <= DONE;
              end
            end
          end
        end
        DONE: begin
          miso    <= MISO_IDLE_VALUE;
          bit_cnt <= '0;
          if (ss_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quick_spi_slave.sv
// Bench for quick_spi_slave: mode 0 MSB-first, mode 3 MSB-first and mode 0 LSB-first
// instances share one master; received words are checked through a per-instance scoreboard.
module tb_quick_spi_slave;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b1;
  logic              sclk_base = 1'b0;
  logic              mosi = 1'b0;
  logic              ss_n = 1'b1;
  logic [15:0]       tx_data = '0;
  logic              tx_valid = 1'b0;
  logic [2:0]        miso, tx_ready, rx_valid, tx_underrun, frame_error;
  logic [2:0][15:0]  rx_data;

  int total = 0;
  int bad = 0;
  int rxv_cnt[3];
  int und_cnt[3];
  int fe_cnt[3];
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  logic [15:0] cap0, cap1, cap2;
  int frame_no = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    wire sclk_i = (gi == 1) ? ~sclk_base : sclk_base;
    quick_spi_slave #(
      .DATA_WIDTH(16),
      .BITS_ORDER((gi == 2) ? 0 : 1),
      .CPOL((gi == 1) ? 1 : 0),
      .CPHA((gi == 1) ? 1 : 0),
      .MISO_IDLE_VALUE(1'b0),
      .SYNC_STAGES(2)
    ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .sclk(sclk_i),
      .mosi(mosi),
      .ss_n(ss_n),
      .miso(miso[gi]),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready[gi]),
      .rx_data(rx_data[gi]),
      .rx_valid(rx_valid[gi]),
      .tx_underrun(tx_underrun[gi]),
      .frame_error(frame_error[gi])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] bitrev(input logic [15:0] x);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = x[15-i];
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [15:0] w);
    tx_data  = w;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic expect_rx(input logic [15:0] w);
    q0.push_back(w);
    q1.push_back(w);
    q2.push_back(bitrev(w));
  endtask

  // Master: mosi changes mid low-phase, sclk_base high for 8 clk per bit.
  task automatic xfer(input logic [15:0] word, input int nbits, input int extra, input bit raise_ss);
    cap0 = '0; cap1 = '0; cap2 = '0;
    frame_no++;
    $display("frame %0d: mosi=%h bits=%0d extra=%0d", frame_no, word, nbits, extra);
    ss_n = 1'b0;
    tick(8);
    for (int i = 0; i < nbits; i++) begin
      mosi = word[15-i];
      tick(4);
      cap0 = {cap0[14:0], miso[0]};
      cap2 = {cap2[14:0], miso[2]};
      sclk_base = 1'b1;
      tick(8);
      cap1 = {cap1[14:0], miso[1]};
      sclk_base = 1'b0;
      tick(4);
    end
    for (int e = 0; e < extra; e++) begin
      tick(4);
      check("extra_miso_lo", miso, 0);
      sclk_base = 1'b1;
      tick(8);
      check("extra_miso_hi", miso, 0);
      sclk_base = 1'b0;
      tick(4);
    end
    tick(4);
    if (raise_ss) begin
      ss_n = 1'b1;
      tick(12);
    end
  endtask

  task automatic check_counts(input int exp_rxv, input int exp_und, input int exp_fe);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rxv_cnt%0d", i), rxv_cnt[i], exp_rxv);
      check($sformatf("und_cnt%0d", i), und_cnt[i], exp_und);
      check($sformatf("fe_cnt%0d", i), fe_cnt[i], exp_fe);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_miso", miso, 0);
    check("rst_tx_ready", tx_ready, 3'b111);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_underrun", tx_underrun, 0);
    check("rst_frame_error", frame_error, 0);
    for (int i = 0; i < 3; i++) check($sformatf("rst_rx_data%0d", i), rx_data[i], 0);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rx_valid[i]) rxv_cnt[i]++;
      if (tx_underrun[i]) und_cnt[i]++;
      if (frame_error[i]) fe_cnt[i]++;
    end
    if (rx_valid[0]) begin
      if (q0.size() == 0) check("rx0_unexpected", rx_valid[0], 0);
      else check("rx0_word", rx_data[0], q0.pop_front());
    end
    if (rx_valid[1]) begin
      if (q1.size() == 0) check("rx1_unexpected", rx_valid[1], 0);
      else check("rx1_word", rx_data[1], q1.pop_front());
    end
    if (rx_valid[2]) begin
      if (q2.size() == 0) check("rx2_unexpected", rx_valid[2], 0);
      else check("rx2_word", rx_data[2], q2.pop_front());
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rxv_cnt[i] = 0; und_cnt[i] = 0; fe_cnt[i] = 0;
    end
    tick(4);
    reset = 1'b0;
    tick(4);
    check_reset_outputs();

    // Full frame with extra master toggles afterwards.
    load_tx(16'hA55A);
    check("tx_ready_loaded", tx_ready, 3'b000);
    expect_rx(16'h1234);
    xfer(16'h1234, 16, 6, 1'b1);
    check("miso_mode0", cap0, 16'hA55A);
    check("miso_mode3", cap1, 16'hA55A);
    check("miso_lsbf", cap2, bitrev(16'hA55A));
    check("tx_ready_after", tx_ready, 3'b111);
    check_counts(1, 0, 0);

    // Empty TX buffer: zeros out, underrun flagged.
    expect_rx(16'hFFFF);
    xfer(16'hFFFF, 16, 0, 1'b1);
    check("miso_under0", cap0, 0);
    check("miso_under1", cap1, 0);
    check("miso_under2", cap2, 0);
    check_counts(2, 1, 0);

    // Aborted after 7 bits: buffer retained, rx_data held.
    load_tx(16'h00FF);
    xfer(16'hABCD, 7, 0, 1'b1);
    check_counts(2, 1, 1);
    check("tx_ready_abort", tx_ready, 3'b000);
    check("rx_data_held", rx_data[0], 16'hFFFF);

    expect_rx(16'h5A3C);
    xfer(16'h5A3C, 16, 0, 1'b1);
    check("miso_retx0", cap0, 16'h00FF);
    check("miso_retx1", cap1, 16'h00FF);
    check("miso_retx2", cap2, 16'hFF00);
    check("tx_ready_retx", tx_ready, 3'b111);
    check_counts(3, 1, 1);

    // enable low: no frame at all.
    enable = 1'b0;
    xfer(16'h1111, 16, 0, 1'b1);
    enable = 1'b1;
    check_counts(3, 1, 1);
    check("rx_data_disabled", rx_data[0], 16'h5A3C);

    // Reset mid-frame with ss_n held low, then clock the master without a new select edge.
    load_tx(16'h3C3C);
    xfer(16'h0F0F, 5, 0, 1'b0);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check_reset_outputs();
    xfer(16'hFFFF, 16, 0, 1'b1);
    check_counts(3, 1, 1);
    check("rx_data_post_reset", rx_data[0], 0);

    // LSB-first instance sends bit 0 first.
    load_tx(16'h0001);
    expect_rx(16'hC3A5);
    xfer(16'hC3A5, 16, 0, 1'b1);
    check("miso_one0", cap0, 16'h0001);
    check("miso_one1", cap1, 16'h0001);
    check("miso_one2_first", cap2[15], 1);
    check("miso_one2", cap2, 16'h8000);
    check_counts(4, 1, 1);

    tick(8);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
